// File: rtl/msu_pkg.sv
// Shared types for the MSU data port prefetcher.
// Holds the fetch FSM state encoding and the default prefetch depth.
package msu_pkg;

   localparam int FIFO_DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } state_t;

endpackage

// File: rtl/msu_data_fetch_if.sv
// Word read port towards the HPS/SDRAM data path.
// master issues mem_req/mem_addr; slave returns a one-cycle mem_ack with mem_rdata.
interface msu_data_fetch_if;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );

endinterface

// File: rtl/msu_byte_fifo.sv
// Byte FIFO accepting one or two bytes per push, one byte per pop, with flush.
// Ports: clk, rst_n, push, two, din[15:0], pop, flush -> count, head.
module msu_byte_fifo
   import msu_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     two,
   input  logic [15:0]              din,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] n_push;
   logic          do_pop;

   // A pop on an empty FIFO is dropped rather than underflowing.
   assign do_pop = pop && (count != '0);
   assign n_push = !push ? '0 : (two ? CW'(2) : CW'(1));
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= din[7:0];
         if (two)
            mem[wr_ptr + AW'(1)] <= din[15:8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(n_push);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + n_push - CW'(do_pop);
      end
   end

endmodule

// File: rtl/msu_data_fetch.sv
// MSU-1 data port prefetcher: streams bytes from word memory into a byte FIFO.
// Ports: CLK, RST_N, seek/seek_addr, data_next -> data_out, data_busy; bus = memory master.
module msu_data_fetch
   import msu_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             seek,
   input  logic [31:0]      seek_addr,
   input  logic             data_next,
   output logic [7:0]       data_out,
   output logic             data_busy,
   msu_data_fetch_if.master bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t        state;
   logic [31:0]   fetch_addr;
   logic          req_q;
   logic [31:0]   addr_q;
   logic          busy_q;
   logic [7:0]    hold;
   logic [7:0]    head;
   logic [CW-1:0] count;
   logic [CW-1:0] free_n;
   logic          room;
   logic          push;
   logic          pop;
   logic [15:0]   push_din;

   assign bus.mem_req  = req_q;
   assign bus.mem_addr = addr_q;
   assign data_busy    = busy_q;

   // Room for a whole word; a pending pop is not counted as credit.
   assign free_n = CW'(FIFO_DEPTH) - count;
   assign room   = free_n >= CW'(2);

   // A seek in the ack cycle turns the returning word stale.
   assign push = (state == REQ) && bus.mem_ack && !seek;
   assign pop  = data_next && !seek;

   // Odd fetch address: only the high byte of the word is wanted.
   assign push_din = fetch_addr[0] ? {8'h00, bus.mem_rdata[15:8]}
                                   : bus.mem_rdata;

   // Empty FIFO shows the last byte that was presented.
   assign data_out = (count != '0) ? head : hold;

   msu_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (push),
      .two   (!fetch_addr[0]),
      .din   (push_din),
      .pop   (pop),
      .flush (seek),
      .count (count),
      .head  (head)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         req_q      <= 1'b0;
         addr_q     <= '0;
         fetch_addr <= '0;
         busy_q     <= 1'b0;
         hold       <= '0;
      end else begin
         hold <= data_out;

         if (seek)
            busy_q <= 1'b1;
         else if (push)
            busy_q <= 1'b0;

         if (seek)
            fetch_addr <= seek_addr;
         else if (push)
            fetch_addr <= fetch_addr + (fetch_addr[0] ? 32'd1 : 32'd2);

         unique case (state)
            IDLE: begin
               // Issue straight from the seek address to save a cycle.
               if (seek) begin
                  req_q  <= 1'b1;
                  addr_q <= {seek_addr[31:1], 1'b0};
                  state  <= REQ;
               end else if (room) begin
                  req_q  <= 1'b1;
                  addr_q <= {fetch_addr[31:1], 1'b0};
                  state  <= REQ;
               end
            end
            REQ: begin
               if (bus.mem_ack) begin
                  req_q <= 1'b0;
                  state <= IDLE;
               end else if (seek) begin
                  state <= DISCARD;
               end
            end
            DISCARD: begin
               if (bus.mem_ack) begin
                  req_q <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               req_q <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msu_data_fetch.sv
// Randomised bench for msu_data_fetch against a byte-stream reference model.
// The model tracks the byte address stream, queued bytes and request ownership.
module tb_msu_data_fetch;

   localparam int DEPTH = 8;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        seek = 1'b0;
   logic [31:0] seek_addr = '0;
   logic        data_next = 1'b0;
   logic [7:0]  data_out;
   logic        data_busy;

   msu_data_fetch_if bus();

   msu_data_fetch #(
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .seek      (seek),
      .seek_addr (seek_addr),
      .data_next (data_next),
      .data_out  (data_out),
      .data_busy (data_busy),
      .bus       (bus)
   );

   always #5 CLK = ~CLK;

   int          n_chk;
   int          n_err;
   int          n_req;
   int          gen;
   int          req_tag;
   int          ack_pct;
   bit          req_act;
   logic [31:0] req_addr;
   logic [31:0] want;
   logic        busy_exp;
   logic [7:0]  last_out;
   logic [7:0]  q [$];
   bit          d_seek;
   bit          d_next;
   bit          d_ack;
   bit          d_stray;
   logic [31:0] d_seek_addr;

   function automatic logic [15:0] mem_word(input logic [31:0] a);
      logic [7:0] lo;
      logic [7:0] hi;
      if (a[31:1] == 31'h80)
         return 16'hBBAA;
      lo = a[8:1] + a[16:9] + 8'h31;
      hi = a[8:1] ^ a[31:24] ^ 8'h5C;
      return {hi, lo};
   endfunction

   function automatic logic [7:0] byte_at(input logic [31:0] a);
      logic [15:0] w;
      w = mem_word({a[31:1], 1'b0});
      return a[0] ? w[15:8] : w[7:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      want     = '0;
      gen++;
      req_act  = 0;
      busy_exp = 1'b0;
      last_out = '0;
      n_req    = 0;
   endtask

   task automatic observe();
      logic [7:0] exp_out;
      exp_out  = (q.size() > 0) ? q[0] : last_out;
      last_out = exp_out;
      chk("data_out", data_out, exp_out);
      chk("busy", data_busy, busy_exp);
      if (bus.mem_req) begin
         if (!req_act) begin
            req_act  = 1;
            req_tag  = gen;
            req_addr = bus.mem_addr;
            n_req++;
            chk("req_addr", bus.mem_addr, {want[31:1], 1'b0});
            chk("req_room", q.size() <= DEPTH - 2, 1);
         end else begin
            chk("addr_hold", bus.mem_addr, req_addr);
         end
      end else if (req_act) begin
         chk("req_held", bus.mem_req, 1);
         req_act = 0;
      end
   endtask

   task automatic cycle();
      logic       a;
      logic [7:0] tmp;
      a = bus.mem_req && (d_ack || ($urandom_range(99) < ack_pct));
      seek          = d_seek;
      seek_addr     = d_seek_addr;
      data_next     = d_next;
      bus.mem_ack   = a || d_stray;
      bus.mem_rdata = a ? mem_word(bus.mem_addr)
                        : (d_stray ? 16'hDEAD : 16'h0000);
      @(posedge CLK);
      if (d_next && !d_seek && q.size() > 0)
         tmp = q.pop_front();
      if (a) begin
         if (!d_seek && req_tag == gen) begin
            if (!want[0]) begin
               q.push_back(byte_at(want));
               q.push_back(byte_at(want + 32'd1));
               want = want + 32'd2;
            end else begin
               q.push_back(byte_at(want));
               want = want + 32'd1;
            end
            busy_exp = 1'b0;
            chk("fifo_bound", q.size() <= DEPTH, 1);
         end
         req_act = 0;
      end
      if (d_seek) begin
         q.delete();
         want     = d_seek_addr;
         gen++;
         busy_exp = 1'b1;
      end
      @(negedge CLK);
      seek        = 1'b0;
      data_next   = 1'b0;
      bus.mem_ack = 1'b0;
      d_seek      = 0;
      d_next      = 0;
      d_ack       = 0;
      d_stray     = 0;
      observe();
   endtask

   task automatic settle_seek(input logic [31:0] a);
      d_seek      = 1;
      d_seek_addr = a;
      cycle();
      for (int i = 0; i < 8; i++) begin
         if (bus.mem_req && req_tag == gen)
            break;
         if (bus.mem_req)
            d_ack = 1;
         cycle();
      end
      chk("settle", bus.mem_req && req_tag == gen, 1);
   endtask

   initial begin
      n_chk         = 0;
      n_err         = 0;
      gen           = 0;
      req_tag       = -1;
      ack_pct       = 0;
      d_seek        = 0;
      d_next        = 0;
      d_ack         = 0;
      d_stray       = 0;
      d_seek_addr   = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      model_reset();

      #3;
      chk("rst_req", bus.mem_req, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_out", data_out, 0);
      chk("rst_busy", data_busy, 0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;

      // Prefetch from 0 with no seek, fill, then backpressure.
      ack_pct = 100;
      repeat (30) cycle();
      chk("fill_nreq", n_req, 4);
      chk("fill_idle", bus.mem_req, 0);
      ack_pct = 0;
      d_next = 1;
      cycle();
      d_next = 1;
      cycle();
      repeat (2) cycle();
      chk("refill_nreq", n_req, 5);
      chk("refill_req", bus.mem_req, 1);
      d_ack = 1;
      cycle();

      // Aligned seek from IDLE.
      d_seek = 1;
      d_seek_addr = 32'h100;
      cycle();
      chk("al_req", bus.mem_req, 1);
      chk("al_addr", bus.mem_addr, 32'h100);
      chk("al_busy", data_busy, 1);
      d_ack = 1;
      cycle();
      chk("al_out0", data_out, 8'hAA);
      chk("al_busy0", data_busy, 0);
      cycle();
      chk("al_next", bus.mem_addr, 32'h102);
      d_next = 1;
      cycle();
      chk("al_out1", data_out, 8'hBB);

      // Seek while a request is outstanding.
      d_seek = 1;
      d_seek_addr = 32'h100;
      cycle();
      d_ack = 1;
      cycle();
      cycle();
      chk("sr_pend", bus.mem_addr, 32'h100);
      d_seek = 1;
      d_seek_addr = 32'h200;
      cycle();
      chk("sr_busy", data_busy, 1);
      d_ack = 1;
      cycle();
      chk("sr_drop", data_busy, 1);
      chk("sr_idle", bus.mem_req, 0);
      cycle();
      chk("sr_req", bus.mem_req, 1);
      chk("sr_addr", bus.mem_addr, 32'h200);
      d_ack = 1;
      cycle();
      chk("sr_busy0", data_busy, 0);
      chk("sr_out", data_out, byte_at(32'h200));

      // Odd seek pushes only the high byte.
      cycle();
      d_seek = 1;
      d_seek_addr = 32'h101;
      cycle();
      d_ack = 1;
      cycle();
      cycle();
      chk("od_addr", bus.mem_addr, 32'h100);
      d_ack = 1;
      cycle();
      chk("od_out", data_out, 8'hBB);
      chk("od_busy", data_busy, 0);
      cycle();
      chk("od_next", bus.mem_addr, 32'h102);
      d_next = 1;
      cycle();
      chk("od_hold", data_out, 8'hBB);
      d_next = 1;
      cycle();
      chk("empty_pop", data_out, 8'hBB);
      d_ack = 1;
      cycle();
      chk("after_empty0", data_out, byte_at(32'h102));
      d_next = 1;
      cycle();
      chk("after_empty1", data_out, byte_at(32'h103));

      // Address wrap.
      settle_seek(32'hFFFF_FFFE);
      chk("wr_addr0", bus.mem_addr, 32'hFFFF_FFFE);
      d_ack = 1;
      cycle();
      cycle();
      chk("wr_addr1", bus.mem_addr, 32'h0);
      chk("wr_out", data_out, byte_at(32'hFFFF_FFFE));

      // Reset in the middle of a request; a late ack is ignored.
      #2;
      RST_N = 1'b0;
      #1;
      chk("mr_req", bus.mem_req, 0);
      chk("mr_busy", data_busy, 0);
      chk("mr_out", data_out, 0);
      model_reset();
      @(negedge CLK);
      chk("mr_addr", bus.mem_addr, 0);
      RST_N = 1'b1;
      d_stray = 1;
      cycle();
      chk("mr_rereq", bus.mem_req, 1);
      chk("mr_readdr", bus.mem_addr, 0);
      chk("mr_stray", data_out, 0);
      d_ack = 1;
      cycle();
      chk("mr_first", data_out, byte_at(32'h0));

      // Random traffic.
      ack_pct = 40;
      for (int i = 0; i < 4000; i++) begin
         d_seek = ($urandom_range(49) == 0);
         if (d_seek) begin
            case ($urandom_range(3))
               0: d_seek_addr = $urandom;
               1: d_seek_addr = 32'hFFFF_FFF0 | 32'($urandom_range(15));
               2: d_seek_addr = 32'($urandom_range(255));
               default: d_seek_addr = $urandom | 32'h1;
            endcase
         end
         if (((i / 500) % 2) == 1)
            d_next = ($urandom_range(19) == 0);
         else
            d_next = ($urandom_range(1) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/msu_data_fetch.md
MSU_DATA_FETCH -- requirements
Module: msu_data_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: prefetch byte buffer depth; power of two, minimum 4.
REQ-002 SHALL have port CLK  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port RST_N  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port seek  in  1  one-cycle pulse from the register block on a $2003 write; loads seek_addr.
REQ-005 SHALL have port seek_addr  in  32  byte address of the next data byte; sampled when seek=1.
REQ-006 SHALL have port data_next  in  1  one-cycle pulse after the SNES reads $2001; pops one byte.
REQ-007 SHALL have port data_out  out  8  current head byte, fed to the $2001 read mux.
REQ-008 SHALL have port data_busy  out  1  status bit 7: high while the head byte is not valid.
REQ-009 SHALL have port mem_req  out  1  read request to the HPS/SDRAM data port.
REQ-010 SHALL have port mem_addr  out  32  word address; always even (bit0=0).
REQ-011 SHALL have port mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
REQ-012 SHALL have port mem_rdata  in  16  little-endian word: [7:0]=even byte, [15:8]=odd byte.

Function
REQ-013 Module SHALL keep fetch_addr[31:0]; it increments by the number of bytes pushed and wraps FFFFFFFF->00000000.
REQ-014 State machine SHALL have states IDLE, REQ and DISCARD.
REQ-015 IDLE->REQ SHALL occur when the FIFO has >=2 free entries; mem_req=1 and mem_addr={fetch_addr[31:1],0} on the next cycle.
REQ-016 In REQ, mem_req and mem_addr SHALL stay constant until mem_ack; on mem_ack the state SHALL return to IDLE.
REQ-017 Push on mem_ack: if fetch_addr[0]=0, push rdata[7:0] then rdata[15:8] (+2); if fetch_addr[0]=1, push rdata[15:8] only (+1).
REQ-018 seek SHALL flush the FIFO, load fetch_addr=seek_addr and set data_busy=1 in the following cycle.
REQ-019 seek arriving in REQ SHALL move to DISCARD: hold mem_req until mem_ack, drop that data, then go to IDLE; the new request SHALL be issued from IDLE.
REQ-020 seek in DISCARD SHALL only reload fetch_addr; the state stays DISCARD.
REQ-021 data_busy SHALL be 1 whenever the FIFO is empty after a seek, and 0 from the cycle after the first push.
REQ-022 data_out SHALL be the FIFO head; when the FIFO is empty it SHALL hold the last value.
REQ-023 data_next with a non-empty FIFO SHALL pop one byte; data_next with an empty FIFO SHALL be ignored, with no underflow.
REQ-024 Same-cycle data_next and push SHALL both take effect, leaving the count at count+pushed-1.
REQ-025 Same-cycle seek and data_next: seek wins and the pop is discarded; same-cycle seek and mem_ack: data is dropped (REQ-019).
REQ-026 The FIFO SHALL never overflow; a request is issued only when free>=2, with the pop credit ignored.
REQ-027 Latency: seek at cycle N -> mem_req at N+1; mem_ack at M -> data_busy=0 and data_out valid at M+1.

Reset
REQ-028 RST_N low SHALL immediately set: state=IDLE, mem_req=0, mem_addr=0, fetch_addr=0, FIFO empty, data_out=0, data_busy=0.
REQ-029 Reset asserted mid-REQ SHALL abandon the request; a late mem_ack after reset SHALL be ignored while in IDLE.
REQ-030 After reset release, the module SHALL prefetch from address 0 with no seek required.

Structure
REQ-031 Package msu_pkg SHALL hold the state enum (IDLE/REQ/DISCARD) and the FIFO_DEPTH default.
REQ-032 Sub-module msu_byte_fifo SHALL provide push-1-or-2, pop, flush, count and head outputs; everything else lives in msu_data_fetch.

Verification
REQ-033 Aligned seek: seek_addr=0x00000100, memory word 0x100=0xBBAA.
  - After ack: data_out=0xAA and busy=0.
  - data_next -> data_out=0xBB.
  - The next request uses mem_addr=0x102.
REQ-034 Odd seek: seek_addr=0x00000101, word=0xBBAA.
  - Only 0xBB is pushed.
  - Next mem_addr=0x102.
  - fetch_addr=0x102 after the push.
REQ-035 Seek during REQ: seek to 0x200 while a request to 0x100 is pending.
  - Ack data for 0x100 is dropped; busy stays 1.
  - Next mem_addr=0x200.
  - First data_out is the byte at 0x200.
REQ-036 Fill and backpressure, FIFO_DEPTH=8, no data_next:
  - Exactly 4 requests are issued; mem_req stays 0 afterwards.
  - Popping 2 bytes enables a 5th request.
REQ-037 Wrap: seek_addr=0xFFFFFFFE.
  - First mem_addr=0xFFFFFFFE.
  - Second mem_addr=0x00000000.
REQ-038 Edge cases:
  - data_next on an empty FIFO leaves data_out unchanged and the count at 0.
  - RST_N pulsed low mid-REQ -> mem_req=0 immediately, busy=0, then mem_addr=0 request.
